ring_mem_requester: RTL and testbench

Per-core initiator for the ring memory protocol. It accepts one cache-line request at a time from the core's cache controller and inserts Address and WriteData slots behind the circulating Token. It collects the 8-word read return from the RDreturn/RDdest bus and handles Retry and Grant slots produced by the memory controller's resend queue. It sits between a core's RingIn/RingOut and its data cache.

---
 rtl/ring_mem_requester.sv | 213 +++++++++++++++++++++
 tb/tb_ring_mem_requester.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_mem_requester.sv
// ring_mem_requester: per-core ring initiator. Takes one cache-line request,
// inserts Address/WriteData slots behind the Token, collects read returns,
// and reacts to Retry and Grant slots addressed to this core.
module ring_mem_requester #(
  parameter int         LINEWORDS = 8,
  parameter logic [3:0] NULLTYPE  = 4'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  input  logic [31:0] RDreturn,
  input  logic [3:0]  RDdest,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [27:0] req_addr,
  output logic        wd_rd,
  output logic [2:0]  wd_idx,
  input  logic [31:0] wd_data,
  output logic        rd_valid,
  output logic [2:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic        done
);

  localparam logic [3:0] TOKEN = 4'd1;
  localparam logic [3:0] ADDR  = 4'd2;
  localparam logic [3:0] WDATA = 4'd3;
  localparam logic [3:0] GRANT = 4'd6;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_EXCL    = 2'd1;
  localparam logic [1:0] OP_UPGRADE = 2'd2;
  localparam logic [1:0] OP_WB      = 2'd3;

  // Write-back inserts the Address plus a full line of WriteData slots.
  localparam logic [3:0]  LAST_EMIT = 4'(LINEWORDS);
  localparam logic [2:0]  LAST_WORD = 3'(LINEWORDS - 1);
  localparam logic [31:0] WB_SLOTS  = 32'(LINEWORDS + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TOKEN, FWD_TRAIN, EMIT, WAIT_DATA, WAIT_GRANT, DONE
  } stateT;

  stateT       stateReg, stateNext;
  logic [1:0]  opReg, opNext;
  logic [27:0] addrReg, addrNext;
  logic [31:0] trainReg, trainNext;
  logic [3:0]  emitReg, emitNext;
  logic [2:0]  wordReg, wordNext;
  logic [31:0] ringReg, ringNext;
  logic [3:0]  typeReg, typeNext;
  logic [3:0]  srcReg, srcNext;

  logic        ownSlot, ownAddr, ownWdata, retryIn, grantMatch, wordHit, isWb;
  logic [3:0]  addrFlags;

  assign ownSlot    = (SourceIn == whichCore);
  assign ownAddr    = ownSlot && (SlotTypeIn == ADDR);
  assign ownWdata   = ownSlot && (SlotTypeIn == WDATA);
  assign retryIn    = ownAddr && RingIn[31];
  assign grantMatch = ownSlot && (SlotTypeIn == GRANT) && (RingIn[27:0] == addrReg);
  assign wordHit    = (RDdest == whichCore);
  assign isWb       = (opReg == OP_WB);

  // Address-slot flag nibble {retry, upgrade, excl, read}; retry always 0 here.
  always_comb begin
    addrFlags = 4'b0000;
    case (opReg)
      OP_READ:    addrFlags = 4'b0001;
      OP_EXCL:    addrFlags = 4'b0011;
      OP_UPGRADE: addrFlags = 4'b0111;
      default:    addrFlags = 4'b0000;
    endcase
  end

  // Next-state, next ring slot and handshake outputs.
  always_comb begin
    stateNext = stateReg;
    opNext    = opReg;
    addrNext  = addrReg;
    trainNext = trainReg;
    emitNext  = emitReg;
    wordNext  = wordReg;
    ringNext  = RingIn;
    typeNext  = SlotTypeIn;
    srcNext   = SourceIn;
    req_ready = (stateReg == IDLE) && !reset;
    done      = (stateReg == DONE) && !reset;
    rd_valid  = (stateReg == WAIT_DATA) && wordHit && !reset;
    rd_idx    = wordReg;
    rd_data   = RDreturn;
    wd_rd     = (stateReg == EMIT) && (emitReg != 4'd0) && !reset;
    wd_idx    = 3'(emitReg - 4'd1);

    // Slots that belong to this core are removed from the ring in any state.
    if (ownAddr || ownWdata || grantMatch) begin
      ringNext = 32'd0;
      typeNext = NULLTYPE;
      srcNext  = 4'd0;
    end

    case (stateReg)
      IDLE: begin
        if (req_valid) begin
          opNext    = req_op;
          addrNext  = req_addr;
          stateNext = WAIT_TOKEN;
        end
      end
      WAIT_TOKEN: begin
        if (SlotTypeIn == TOKEN) begin
          ringNext = RingIn + (isWb ? WB_SLOTS : 32'd1);
          emitNext = 4'd0;
          if (RingIn == 32'd0) begin
            stateNext = EMIT;
          end else begin
            trainNext = RingIn;
            stateNext = FWD_TRAIN;
          end
        end
      end
      FWD_TRAIN: begin
        trainNext = trainReg - 32'd1;
        if (trainReg == 32'd1) begin
          stateNext = EMIT;
        end
      end
      EMIT: begin
        srcNext  = whichCore;
        emitNext = emitReg + 4'd1;
        if (emitReg == 4'd0) begin
          typeNext = ADDR;
          ringNext = {addrFlags, addrReg};
        end else begin
          typeNext = WDATA;
          ringNext = wd_data;
        end
        if (isWb ? (emitReg == LAST_EMIT) : (emitReg == 4'd0)) begin
          wordNext = 3'd0;
          if (isWb) begin
            stateNext = DONE;
          end else if (opReg == OP_UPGRADE) begin
            stateNext = WAIT_GRANT;
          end else begin
            stateNext = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        // A matching data word takes priority over a simultaneous Retry.
        if (wordHit) begin
          wordNext = wordReg + 3'd1;
          if (wordReg == LAST_WORD) begin
            stateNext = DONE;
          end
        end else if (retryIn) begin
          wordNext  = 3'd0;
          stateNext = WAIT_TOKEN;
        end
      end
      WAIT_GRANT: begin
        if (grantMatch) begin
          stateNext = DONE;
        end else if (retryIn) begin
          stateNext = WAIT_TOKEN;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and registered ring slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
      opReg    <= 2'd0;
      addrReg  <= 28'd0;
      trainReg <= 32'd0;
      emitReg  <= 4'd0;
      wordReg  <= 3'd0;
      ringReg  <= 32'd0;
      typeReg  <= NULLTYPE;
      srcReg   <= 4'd0;
    end else begin
      stateReg <= stateNext;
      opReg    <= opNext;
      addrReg  <= addrNext;
      trainReg <= trainNext;
      emitReg  <= emitNext;
      wordReg  <= wordNext;
      ringReg  <= ringNext;
      typeReg  <= typeNext;
      srcReg   <= srcNext;
    end
  end

  assign RingOut     = ringReg;
  assign SlotTypeOut = typeReg;
  assign SourceOut   = srcReg;

endmodule

// File: tb/tb_ring_mem_requester.sv
// Directed bench for ring_mem_requester: read, write-back, retry, upgrade,
// passthrough/strip and mid-request reset.
module tb_ring_mem_requester;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  whichCore;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut;
  logic [3:0]  SourceOut;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [27:0] req_addr;
  logic        wd_rd;
  logic [2:0]  wd_idx;
  logic [31:0] wd_data;
  logic        rd_valid;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  ring_mem_requester #(.LINEWORDS(8), .NULLTYPE(4'd7)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .wd_rd(wd_rd), .wd_idx(wd_idx), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data), .done(done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    SlotTypeIn = t;
    SourceIn   = s;
    RingIn     = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'd2, 4'd3, 32'h5555_0000);
    step();
    step();
    vectors++; if (RingOut !== 32'd0) begin $display("FAIL reset_ring: got %h want %h", RingOut, 32'd0); miscompares++; end
    vectors++; if (SlotTypeOut !== 4'd7) begin $display("FAIL reset_type: got %0d want 7", SlotTypeOut); miscompares++; end
    vectors++; if (SourceOut !== 4'd0) begin $display("FAIL reset_src: got %0d want 0", SourceOut); miscompares++; end
    vectors++; if (req_ready !== 1'b0) begin $display("FAIL reset_ready_during: got %b want 0", req_ready); miscompares++; end
    vectors++; if ({rd_valid, wd_rd, done} !== 3'b000) begin $display("FAIL reset_strobes: got %b want 000", {rd_valid, wd_rd, done}); miscompares++; end
    reset = 1'b0;
    drive(4'd7, 4'd0, 32'd0);
    #1;
    vectors++; if (req_ready !== 1'b1) begin $display("FAIL reset_ready_after: got %b want 1", req_ready); miscompares++; end
    $display("test_reset: reset values checked");
  endtask

  task automatic test_read();
    int w;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 28'h000_0040;
    #1;
    vectors++; if (req_ready !== 1'b1) begin $display("FAIL read_ready: got %b want 1", req_ready); miscompares++; end
    step();
    req_valid = 1'b0;
    drive(4'd1, 4'd9, 32'd0);
    #1;
    vectors++; if (req_ready !== 1'b0) begin $display("FAIL read_ready_busy: got %b want 0", req_ready); miscompares++; end
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd1, 4'd9, 32'd1}) begin $display("FAIL read_token: got %0d/%0d/%h want 1/9/00000001", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    drive(4'd7, 4'd0, 32'd0);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd2, 4'd5, 32'h1000_0040}) begin $display("FAIL read_addr: got %0d/%0d/%h want 2/5/10000040", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    w = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 3) begin
        RDdest = 4'd2; RDreturn = 32'hFF;
        #1;
        vectors++; if (rd_valid !== 1'b0) begin $display("FAIL read_gap_valid: got %b want 0", rd_valid); miscompares++; end
      end else begin
        RDdest = 4'd5; RDreturn = 32'hA0 + 32'(w);
        #1;
        vectors++; if ({rd_valid, rd_idx, rd_data} !== {1'b1, 3'(w), 32'hA0 + 32'(w)}) begin $display("FAIL read_word%0d: got %b/%0d/%h want 1/%0d/%h", w, rd_valid, rd_idx, rd_data, w, 32'hA0 + 32'(w)); miscompares++; end
        vectors++; if (done !== 1'b0) begin $display("FAIL read_early_done: got %b want 0", done); miscompares++; end
        w++;
      end
      step();
    end
    RDdest = 4'd0;
    #1;
    vectors++; if (done !== 1'b1) begin $display("FAIL read_done: got %b want 1", done); miscompares++; end
    step();
    vectors++; if ({done, req_ready} !== 2'b01) begin $display("FAIL read_done_end: got done/ready %b want 01", {done, req_ready}); miscompares++; end
    $display("test_read: request 0x40 completed");
  endtask

  task automatic test_writeback();
    req_valid = 1'b1; req_op = 2'd3; req_addr = 28'h000_0080;
    step();
    req_valid = 1'b0;
    drive(4'd1, 4'd9, 32'd3);
    step();
    vectors++; if ({SlotTypeOut, RingOut} !== {4'd1, 32'd12}) begin $display("FAIL wb_token: got %0d/%h want 1/0000000c", SlotTypeOut, RingOut); miscompares++; end
    for (int j = 0; j < 3; j++) begin
      drive(4'd2, 4'd3, 32'h2000_0000 + 32'(j));
      step();
      vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd2, 4'd3, 32'h2000_0000 + 32'(j)}) begin $display("FAIL wb_fwd%0d: got %0d/%0d/%h want 2/3/%h", j, SlotTypeOut, SourceOut, RingOut, 32'h2000_0000 + 32'(j)); miscompares++; end
    end
    drive(4'd7, 4'd0, 32'd0);
    #1;
    vectors++; if (wd_rd !== 1'b0) begin $display("FAIL wb_rd_on_addr: got %b want 0", wd_rd); miscompares++; end
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd2, 4'd5, 32'h0000_0080}) begin $display("FAIL wb_addr: got %0d/%0d/%h want 2/5/00000080", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    for (int i = 0; i < 8; i++) begin
      wd_data = 32'hD000_00D0 + 32'(i);
      #1;
      vectors++; if ({wd_rd, wd_idx} !== {1'b1, 3'(i)}) begin $display("FAIL wb_fetch%0d: got %b/%0d want 1/%0d", i, wd_rd, wd_idx, i); miscompares++; end
      step();
      vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd3, 4'd5, 32'hD000_00D0 + 32'(i)}) begin $display("FAIL wb_data%0d: got %0d/%0d/%h want 3/5/%h", i, SlotTypeOut, SourceOut, RingOut, 32'hD000_00D0 + 32'(i)); miscompares++; end
    end
    vectors++; if ({done, wd_rd} !== 2'b10) begin $display("FAIL wb_done: got done/wd_rd %b want 10", {done, wd_rd}); miscompares++; end
    step();
    vectors++; if (done !== 1'b0) begin $display("FAIL wb_done_end: got %b want 0", done); miscompares++; end
    $display("test_writeback: request 0x80 posted");
  endtask

  task automatic test_retry();
    req_valid = 1'b1; req_op = 2'd0; req_addr = 28'h000_0040;
    step();
    req_valid = 1'b0;
    drive(4'd1, 4'd9, 32'd0);
    step();
    drive(4'd7, 4'd0, 32'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      RDdest = 4'd5; RDreturn = 32'hB0 + 32'(i);
      step();
    end
    RDdest = 4'd0;
    drive(4'd2, 4'd5, 32'h9000_0040);
    step();
    vectors++; if ({SlotTypeOut, RingOut} !== {4'd7, 32'd0}) begin $display("FAIL retry_strip: got %0d/%h want 7/00000000", SlotTypeOut, RingOut); miscompares++; end
    drive(4'd7, 4'd0, 32'd0);
    step();
    drive(4'd1, 4'd9, 32'd2);
    step();
    vectors++; if ({SlotTypeOut, RingOut} !== {4'd1, 32'd3}) begin $display("FAIL retry_token: got %0d/%h want 1/00000003", SlotTypeOut, RingOut); miscompares++; end
    for (int j = 0; j < 2; j++) begin
      drive(4'd3, 4'd4, 32'h7000_0000 + 32'(j));
      step();
    end
    drive(4'd7, 4'd0, 32'd0);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd2, 4'd5, 32'h1000_0040}) begin $display("FAIL retry_readdr: got %0d/%0d/%h want 2/5/10000040", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    for (int i = 0; i < 8; i++) begin
      RDdest = 4'd5; RDreturn = 32'hC0 + 32'(i);
      // Final word collides with a Retry; the data word wins.
      if (i == 7) drive(4'd2, 4'd5, 32'h9000_0040);
      #1;
      vectors++; if ({rd_valid, rd_idx} !== {1'b1, 3'(i)}) begin $display("FAIL retry_word%0d: got %b/%0d want 1/%0d", i, rd_valid, rd_idx, i); miscompares++; end
      step();
    end
    RDdest = 4'd0;
    drive(4'd7, 4'd0, 32'd0);
    #1;
    vectors++; if (done !== 1'b1) begin $display("FAIL retry_done: got %b want 1", done); miscompares++; end
    step();
    $display("test_retry: request 0x40 completed after retry");
  endtask

  task automatic test_upgrade();
    req_valid = 1'b1; req_op = 2'd2; req_addr = 28'h000_0123;
    step();
    req_valid = 1'b0;
    drive(4'd1, 4'd9, 32'd0);
    step();
    drive(4'd7, 4'd0, 32'd0);
    step();
    vectors++; if ({SlotTypeOut, RingOut} !== {4'd2, 32'h7000_0123}) begin $display("FAIL upg_addr: got %0d/%h want 2/70000123", SlotTypeOut, RingOut); miscompares++; end
    drive(4'd6, 4'd5, 32'h0000_0124);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd6, 4'd5, 32'h0000_0124}) begin $display("FAIL upg_badgrant: got %0d/%0d/%h want 6/5/00000124", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    vectors++; if (done !== 1'b0) begin $display("FAIL upg_early_done: got %b want 0", done); miscompares++; end
    drive(4'd6, 4'd5, 32'h0000_0123);
    step();
    vectors++; if ({SlotTypeOut, done} !== {4'd7, 1'b1}) begin $display("FAIL upg_grant: got type/done %0d/%b want 7/1", SlotTypeOut, done); miscompares++; end
    drive(4'd7, 4'd0, 32'd0);
    step();
    vectors++; if (done !== 1'b0) begin $display("FAIL upg_done_end: got %b want 0", done); miscompares++; end
    $display("test_upgrade: grant for 0x123 received");
  endtask

  task automatic test_passthrough();
    drive(4'd2, 4'd3, 32'h1234_5678);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd2, 4'd3, 32'h1234_5678}) begin $display("FAIL pass_addr: got %0d/%0d/%h want 2/3/12345678", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    drive(4'd3, 4'd4, 32'hCAFE_BABE);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd3, 4'd4, 32'hCAFE_BABE}) begin $display("FAIL pass_wdata: got %0d/%0d/%h want 3/4/cafebabe", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    drive(4'd2, 4'd5, 32'h1000_0040);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd7, 4'd0, 32'd0}) begin $display("FAIL pass_own_strip: got %0d/%0d/%h want 7/0/00000000", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    drive(4'd1, 4'd9, 32'd4);
    step();
    vectors++; if ({SlotTypeOut, RingOut} !== {4'd1, 32'd4}) begin $display("FAIL pass_token: got %0d/%h want 1/00000004", SlotTypeOut, RingOut); miscompares++; end
    drive(4'd7, 4'd0, 32'd0);
    $display("test_passthrough: 4 slots checked");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_op = 2'd0; req_addr = 28'h000_0040;
    step();
    req_valid = 1'b0;
    drive(4'd1, 4'd9, 32'd0);
    step();
    drive(4'd7, 4'd0, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      RDdest = 4'd5; RDreturn = 32'hE0 + 32'(i);
      step();
    end
    reset = 1'b1;
    drive(4'd2, 4'd3, 32'h4444_4444);
    step();
    vectors++; if ({SlotTypeOut, SourceOut, RingOut} !== {4'd7, 4'd0, 32'd0}) begin $display("FAIL rstmid_ring: got %0d/%0d/%h want 7/0/00000000", SlotTypeOut, SourceOut, RingOut); miscompares++; end
    vectors++; if ({rd_valid, wd_rd, done, req_ready} !== 4'b0000) begin $display("FAIL rstmid_strobes: got %b want 0000", {rd_valid, wd_rd, done, req_ready}); miscompares++; end
    reset = 1'b0;
    RDdest = 4'd0;
    drive(4'd7, 4'd0, 32'd0);
    #1;
    vectors++; if ({req_ready, done} !== 2'b10) begin $display("FAIL rstmid_ready: got ready/done %b want 10", {req_ready, done}); miscompares++; end
    step();
    vectors++; if ({req_ready, done} !== 2'b10) begin $display("FAIL rstmid_nodone: got ready/done %b want 10", {req_ready, done}); miscompares++; end
    $display("test_reset_mid: request abandoned");
  endtask

  initial begin
    whichCore = 4'd5;
    reset = 1'b1;
    RingIn = 32'd0; SlotTypeIn = 4'd7; SourceIn = 4'd0;
    RDreturn = 32'd0; RDdest = 4'd0;
    req_valid = 1'b0; req_op = 2'd0; req_addr = 28'd0;
    wd_data = 32'd0;
    test_reset();
    test_read();
    test_writeback();
    test_retry();
    test_upgrade();
    test_passthrough();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
